// File: rtl/fsm_txn_checker.sv
// Passive checker for the IDLE/INIT/DECODE pi/po controller: reference model,
// transition bins and coverage. FSMCHK_SEQ_EN adds full-walk counting.
module fsm_txn_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clear,
  input  logic             obs_pi,
  input  logic             obs_po,
  input  logic [1:0]       obs_state,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic [5:0]       trans_hit,
  output logic [5:0]       covered,
  output logic             all_covered,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    DECODE = 2'd2
  } state_e;

  state_e           model_q;
  logic [CNT_W-1:0] cnt_q [6];
  logic [5:0]       hit_q;
  logic [5:0]       cov_q;
  logic             mis_q;
  logic             err_q;
  logic [CNT_W-1:0] errc_q;

  logic [1:0]       exp_st_d;
  logic             exp_po_d;
  logic [5:0]       hit_d;
  logic             mis_d;

  always_comb begin
    exp_st_d = IDLE;
    exp_po_d = 1'b0;
    hit_d    = '0;
    case (model_q)
      IDLE: begin
        exp_st_d = obs_pi ? INIT : IDLE;
        exp_po_d = ~obs_pi;
        hit_d[0] = (obs_state == 2'd0);
        hit_d[1] = (obs_state == 2'd1);
      end
      INIT: begin
        exp_st_d = obs_pi ? DECODE : IDLE;
        exp_po_d = obs_pi;
        hit_d[2] = (obs_state == 2'd0);
        hit_d[3] = (obs_state == 2'd2);
      end
      DECODE: begin
        exp_st_d = obs_pi ? IDLE : DECODE;
        exp_po_d = 1'b1;
        hit_d[4] = (obs_state == 2'd2);
        hit_d[5] = (obs_state == 2'd0);
      end
      default: ;
    endcase
  end

  assign mis_d = (obs_state != exp_st_d) | (obs_po != exp_po_d)
               | (obs_state == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q <= IDLE;
      hit_q   <= '0;
      cov_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else if (clear) begin
      hit_q  <= '0;
      cov_q  <= '0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      errc_q <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else if (sample_en) begin
      hit_q <= hit_d;
      cov_q <= cov_q | hit_d;
      mis_q <= mis_d;
      for (int i = 0; i < 6; i++)
        if (hit_d[i] && !(&cnt_q[i]))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      if (mis_d) begin
        err_q <= 1'b1;
        if (!(&errc_q)) errc_q <= errc_q + 1'b1;
      end
      // resync so a single fault does not cascade
      model_q <= (obs_state == 2'd3) ? IDLE : state_e'(obs_state);
    end else begin
      hit_q <= '0;
      mis_q <= 1'b0;
    end
  end

`ifdef FSMCHK_SEQ_EN
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] seq_q, seq_d;

  always_comb begin
    step_d = 2'd0;
    seq_d  = seq_q;
    if (!mis_d) begin
      if (hit_d[1]) begin
        step_d = 2'd1;
      end else if (hit_d[3] && step_q == 2'd1) begin
        step_d = 2'd2;
      end else if (hit_d[5] && step_q == 2'd2) begin
        if (!(&seq_q)) seq_d = seq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 2'd0;
      seq_q  <= '0;
    end else if (clear) begin
      step_q <= 2'd0;
      seq_q  <= '0;
    end else if (sample_en) begin
      step_q <= step_d;
      seq_q  <= seq_d;
    end
  end

  assign seq_count = seq_q;
`else
  assign seq_count = '0;
`endif

  always_comb begin
    cnt_out = '0;
    case (sel)
      3'd0: cnt_out = cnt_q[0];
      3'd1: cnt_out = cnt_q[1];
      3'd2: cnt_out = cnt_q[2];
      3'd3: cnt_out = cnt_q[3];
      3'd4: cnt_out = cnt_q[4];
      3'd5: cnt_out = cnt_q[5];
      default: cnt_out = '0;
    endcase
  end

  assign trans_hit   = hit_q;
  assign covered     = cov_q;
  assign all_covered = &cov_q;
  assign mismatch    = mis_q;
  assign err_sticky  = err_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_fsm_txn_checker.sv
// Directed bench for fsm_txn_checker; a CNT_W=2 copy shares the stimulus
// for the saturation case.
module tb_fsm_txn_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic       obs_pi = 1'b0;
  logic       obs_po = 1'b0;
  logic [1:0] obs_state = 2'd0;
  logic [2:0] sel = 3'd0;

  logic [7:0] cnt_out, err_count, seq_count;
  logic [5:0] trans_hit, covered;
  logic       all_covered, mismatch, err_sticky;

  logic [1:0] s_cnt_out, s_err_count, s_seq_count;
  logic [5:0] s_trans_hit, s_covered;
  logic       s_all_covered, s_mismatch, s_err_sticky;

  int nchecks = 0;
  int nerr = 0;

`ifdef FSMCHK_SEQ_EN
  localparam logic [7:0] SEQ1 = 8'd1;
`else
  localparam logic [7:0] SEQ1 = 8'd0;
`endif

  always #5 clk = ~clk;

  fsm_txn_checker #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear),
    .obs_pi(obs_pi), .obs_po(obs_po), .obs_state(obs_state), .sel(sel),
    .cnt_out(cnt_out), .trans_hit(trans_hit), .covered(covered),
    .all_covered(all_covered), .mismatch(mismatch),
    .err_sticky(err_sticky), .err_count(err_count),
    .seq_count(seq_count)
  );

  fsm_txn_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear),
    .obs_pi(obs_pi), .obs_po(obs_po), .obs_state(obs_state), .sel(sel),
    .cnt_out(s_cnt_out), .trans_hit(s_trans_hit), .covered(s_covered),
    .all_covered(s_all_covered), .mismatch(s_mismatch),
    .err_sticky(s_err_sticky), .err_count(s_err_count),
    .seq_count(s_seq_count)
  );

  task automatic drive(input logic pi, input logic po,
                       input logic [1:0] st);
    obs_pi    = pi;
    obs_po    = po;
    obs_state = st;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++;
    if ({trans_hit, covered, all_covered, mismatch, err_sticky} !== 15'd0) begin
      nerr++;
      $display("FAIL reset_flags got %h want 0",
               {trans_hit, covered, all_covered, mismatch, err_sticky});
    end
    nchecks++;
    if ({err_count, seq_count} !== 16'd0) begin
      nerr++;
      $display("FAIL reset_counts got %h want 0", {err_count, seq_count});
    end
  endtask

  task automatic test_walk();
    logic [5:0] exp_hit [3];
    logic       pos  [3];
    logic [1:0] sts  [3];
    exp_hit = '{6'h02, 6'h08, 6'h20};
    pos     = '{1'b0, 1'b1, 1'b1};
    sts     = '{2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pos[i], sts[i]);
      nchecks++;
      if (trans_hit !== exp_hit[i] || mismatch !== 1'b0) begin
        nerr++;
        $display("FAIL walk_step%0d hit=%h mis=%b want hit=%h mis=0",
                 i, trans_hit, mismatch, exp_hit[i]);
      end
    end
    nchecks++;
    if (covered !== 6'h2A) begin
      nerr++;
      $display("FAIL walk_covered got %h want 2a", covered);
    end
    nchecks++;
    if (seq_count !== SEQ1) begin
      nerr++;
      $display("FAIL walk_seq got %0d want %0d", seq_count, SEQ1);
    end
  endtask

  task automatic test_cover_all();
    logic       pis [7];
    logic       pos [7];
    logic [1:0] sts [7];
    pis = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pos = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sts = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 7; i++) drive(pis[i], pos[i], sts[i]);
    nchecks++;
    if (covered !== 6'h3F || all_covered !== 1'b1) begin
      nerr++;
      $display("FAIL cover_all cov=%h all=%b want 3f 1",
               covered, all_covered);
    end
    nchecks++;
    if (err_count !== 8'd0) begin
      nerr++;
      $display("FAIL cover_errc got %0d want 0", err_count);
    end
    sel = 3'd0;
    #1;
    nchecks++;
    if (cnt_out !== 8'd1) begin
      nerr++;
      $display("FAIL cover_cnt0 got %0d want 1", cnt_out);
    end
    sel = 3'd1;
    #1;
    nchecks++;
    if (cnt_out !== 8'd2) begin
      nerr++;
      $display("FAIL cover_cnt1 got %0d want 2", cnt_out);
    end
    sel = 3'd6;
    #1;
    nchecks++;
    if (cnt_out !== 8'd0) begin
      nerr++;
      $display("FAIL cover_sel6 got %0d want 0", cnt_out);
    end
    sel = 3'd0;
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(1'b1, 1'b1, 2'd1);
    nchecks++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || err_sticky !== 1'b1
        || trans_hit !== 6'h02) begin
      nerr++;
      $display("FAIL mis_po mis=%b ec=%0d es=%b hit=%h want 1 1 1 02",
               mismatch, err_count, err_sticky, trans_hit);
    end
    drive(1'b0, 1'b0, 2'd3);
    nchecks++;
    if (mismatch !== 1'b1 || trans_hit !== 6'h00 || err_count !== 8'd2) begin
      nerr++;
      $display("FAIL mis_ill mis=%b hit=%h ec=%0d want 1 00 2",
               mismatch, trans_hit, err_count);
    end
    drive(1'b0, 1'b1, 2'd0);
    nchecks++;
    if (mismatch !== 1'b0 || trans_hit !== 6'h01) begin
      nerr++;
      $display("FAIL mis_resync mis=%b hit=%h want 0 01",
               mismatch, trans_hit);
    end
    drive(1'b1, 1'b1, 2'd1);
    @(posedge clk);
    #1;
    nchecks++;
    if (mismatch !== 1'b0 || err_sticky !== 1'b1 || err_count !== 8'd3) begin
      nerr++;
      $display("FAIL mis_idle mis=%b es=%b ec=%0d want 0 1 3",
               mismatch, err_sticky, err_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'd0);
    sel = 3'd0;
    #1;
    nchecks++;
    if (s_cnt_out !== 2'd3) begin
      nerr++;
      $display("FAIL sat_w2 got %0d want 3", s_cnt_out);
    end
    nchecks++;
    if (cnt_out !== 8'd5) begin
      nerr++;
      $display("FAIL sat_w8 got %0d want 5", cnt_out);
    end
  endtask

  task automatic test_clear();
    logic [7:0] sum;
    do_reset();
    drive(1'b1, 1'b1, 2'd1);
    clear = 1'b1;
    drive(1'b1, 1'b1, 2'd2);
    clear = 1'b0;
    sum = '0;
    for (int i = 0; i < 6; i++) begin
      sel = 3'(i);
      #1;
      sum = sum | cnt_out;
    end
    sel = 3'd0;
    nchecks++;
    if (sum !== 8'd0 || covered !== 6'd0 || err_sticky !== 1'b0
        || err_count !== 8'd0) begin
      nerr++;
      $display("FAIL clear_state cnt=%h cov=%h es=%b ec=%0d want 0",
               sum, covered, err_sticky, err_count);
    end
    nchecks++;
    if (trans_hit !== 6'd0 || mismatch !== 1'b0 || seq_count !== 8'd0) begin
      nerr++;
      $display("FAIL clear_pulse hit=%h mis=%b seq=%0d want 0",
               trans_hit, mismatch, seq_count);
    end
    drive(1'b1, 1'b1, 2'd2);
    nchecks++;
    if (trans_hit !== 6'h08 || mismatch !== 1'b0) begin
      nerr++;
      $display("FAIL clear_model hit=%h mis=%b want 08 0",
               trans_hit, mismatch);
    end
  endtask

  task automatic test_reset_midwalk();
    do_reset();
    drive(1'b1, 1'b0, 2'd1);
    drive(1'b1, 1'b1, 2'd2);
    drive(1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 2'd1);
    reset = 1'b1;
    #2;
    nchecks++;
    if (seq_count !== 8'd0 || trans_hit !== 6'd0 || covered !== 6'd0) begin
      nerr++;
      $display("FAIL rst_async seq=%0d hit=%h cov=%h want 0",
               seq_count, trans_hit, covered);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 2'd0);
    nchecks++;
    if (trans_hit !== 6'h01 || mismatch !== 1'b0) begin
      nerr++;
      $display("FAIL rst_model hit=%h mis=%b want 01 0",
               trans_hit, mismatch);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_cover_all();
    test_mismatch();
    test_saturate();
    test_clear();
    test_reset_midwalk();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
